// File: rtl/gf2_poly_divider_pkg.sv
// Shared definitions for the GF(2)[x] long divider.
package gf2_poly_divider_pkg;
  localparam int N_DEF = 224;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DIV
  } div_state_t;
endpackage

// File: rtl/gf2_div_step.sv
// One carry-less long-division step.
// Shifts in a dividend bit, then conditionally subtracts (XORs) the divisor.
module gf2_div_step #(
  parameter int N  = 224,
  parameter int DW = $clog2(N)
) (
  input  logic [N-1:0]  work_r,
  input  logic          in_bit,
  input  logic [N-1:0]  b,
  input  logic [DW-1:0] deg,
  output logic [N-1:0]  next_r,
  output logic          qb
);
  logic [N:0] s;

  always_comb begin
    s      = {work_r, in_bit};
    qb     = s[deg];
    next_r = s[N-1:0] ^ (qb ? b : '0);
  end
endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] divider: q*b ^ r == a, deg(r) < deg(b).
// Scans for deg(b), then produces one quotient bit per cycle.
import gf2_poly_divider_pkg::*;

module gf2_poly_divider #(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic           err,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r
);
  localparam int CW = $clog2(2*N);
  localparam int DW = $clog2(N);
  localparam logic [CW-1:0] CNT_TOP = CW'(2*N-1);
  localparam logic [DW-1:0] IDX_TOP = DW'(N-1);

  div_state_t      state;
  logic [2*N-1:0]  a_reg;
  logic [N-1:0]    b_reg;
  logic [DW-1:0]   idx;
  logic [DW-1:0]   deg;
  logic [CW-1:0]   cnt;
  logic [2*N-2:0]  work_q;
  logic [N-1:0]    work_r;
  logic [N-1:0]    next_r;
  logic            qb;
  logic [2*N-1:0]  q_next;

  gf2_div_step #(
    .N  (N),
    .DW (DW)
  ) u_step (
    .work_r (work_r),
    .in_bit (a_reg[cnt]),
    .b      (b_reg),
    .deg    (deg),
    .next_r (next_r),
    .qb     (qb)
  );

  assign q_next = {work_q, qb};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      deg    <= '0;
      cnt    <= '0;
      work_q <= '0;
      work_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
      q      <= '0;
      r      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            idx    <= IDX_TOP;
            work_q <= '0;
            work_r <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            if (b == '0) begin
              q     <= '0;
              r     <= '0;
              err   <= 1'b1;
              valid <= 1'b1;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // b_reg is nonzero here, so idx cannot wrap
          if (b_reg[idx]) begin
            deg   <= idx;
            cnt   <= CNT_TOP;
            state <= ST_DIV;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DIV: begin
          work_r <= next_r;
          work_q <= q_next[2*N-2:0];
          if (cnt == '0) begin
            q     <= q_next;
            r     <= next_r;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and random scoreboard bench for gf2_poly_divider.
module tb_gf2_poly_divider;
  localparam int N = 224;
  localparam int LIMIT = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] a_i;
  logic [N-1:0]   b_i;
  logic           busy;
  logic           done;
  logic           valid;
  logic           err;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;

  typedef struct {
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           err;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;

  gf2_poly_divider #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .err   (err),
    .q     (q),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [2*N-1:0] obs, logic [2*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N-1:0] rnd_wide();
    logic [2*N-1:0] v;
    for (int i = 0; i < 2*N/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [3*N-1:0] clmul(logic [2*N-1:0] x, logic [N-1:0] y);
    logic [3*N-1:0] acc = '0;
    logic [3*N-1:0] xe = {{N{1'b0}}, x};
    for (int i = 0; i < N; i++)
      if (y[i]) acc ^= xe << i;
    return acc;
  endfunction

  function automatic int degree(logic [N-1:0] y);
    for (int i = N-1; i >= 0; i--)
      if (y[i]) return i;
    return -1;
  endfunction

  task automatic model_div(input logic [2*N-1:0] x, input logic [N-1:0] y,
                           output logic [2*N-1:0] qq, output logic [N-1:0] rr);
    logic [2*N-1:0] rem = x;
    logic [2*N-1:0] ye = {{N{1'b0}}, y};
    int d = degree(y);
    qq = '0;
    for (int i = 2*N-1; i >= d; i--)
      if (rem[i]) begin
        qq[i-d] = 1'b1;
        rem ^= ye << (i-d);
      end
    rr = rem[N-1:0];
  endtask

  task automatic launch(input logic [2*N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    e.a = x;
    e.b = y;
    if (y == '0) begin
      e.q = '0; e.r = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      model_div(x, y, e.q, e.r);
      e.err = 1'b0;
      e.lat = 1 + (N - degree(y)) + 2*N;
    end
    sb.push_back(e);
    a_i = x;
    b_i = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_check(string tag);
    exp_t e;
    logic [3*N-1:0] p;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_done"}, done, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, lat, e.lat);
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_valid"}, valid, 1);
      chk({tag, "_busy"}, busy, 0);
      if (e.b != '0) begin
        p = clmul(q, e.b) ^ {{2*N{1'b0}}, r};
        chk({tag, "_recon"}, p[2*N-1:0], e.a);
      end
    end
  endtask

  initial begin
    logic [2*N-1:0] x, w, ra;
    logic [N-1:0]   y, rr, one;
    logic [2*N-1:0] one2;
    logic [3*N-1:0] pr;
    int d;

    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: divide by zero
    launch(448'h15, '0);
    wait_check("t1");
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_err_hold", err, 1);

    // T2
    launch(448'h15, 224'h3);
    wait_check("t2");
    chk("t2_q_const", q, 448'hC);
    chk("t2_r_const", r, 1);

    // T3
    x = rnd_wide();
    launch(x, 224'h1);
    wait_check("t3_b1");
    chk("t3_b1_q", q, x);
    x = rnd_wide();
    one = 1;
    launch(x, one << 223);
    wait_check("t3_top");
    chk("t3_top_q", q, x >> 223);
    w = x & ((448'h1 << 223) - 1);
    chk("t3_top_r", r, w);

    // T4: constructed quotient/remainder
    one2 = 1;
    for (int k = 0; k < 20; k++) begin
      d = $urandom_range(1, N-1);
      w = rnd_wide();
      y = (w[N-1:0] & ((one << d) - 1)) | (one << d);
      w = rnd_wide();
      rr = w[N-1:0] & ((one << d) - 1);
      x = rnd_wide() & ((one2 << (2*N-d)) - 1);
      pr = clmul(x, y);
      ra = pr[2*N-1:0] ^ {{N{1'b0}}, rr};
      launch(ra, y);
      wait_check("t4");
      chk("t4_qx", q, x);
      chk("t4_rr", r, rr);
    end
    for (int k = 0; k < 5; k++) begin
      w = rnd_wide();
      y = w[N-1:0] >> $urandom_range(0, N-1);
      if (y == '0) y = 224'h5;
      launch(rnd_wide(), y);
      wait_check("t4_rand");
    end

    // T5: start while busy is ignored
    launch(448'h15, 224'h3);
    repeat (40) begin
      a_i = rnd_wide();
      w = rnd_wide();
      b_i = w[N-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    wait_check("t5_busy");
    @(posedge clk); #1;
    chk("t5_single_done", done, 0);
    chk("t5_idle", busy, 0);
    launch(rnd_wide(), 224'hB);
    wait_check("t5_a");
    launch(448'h15, 224'h3);
    wait_check("t5_b2b");

    // T6: reset aborts mid-division
    launch(rnd_wide(), 224'h3);
    repeat (400) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_valid", valid, 0);
    chk("t6_q", q, 0);
    chk("t6_r", r, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_no_done", done, 0);
    end
    launch(448'h15, 224'h3);
    wait_check("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
